// File: rtl/pacman_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pacman_mover_pkg
// Brief    : Shared tile width, heading encoding and mover FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package pacman_mover_pkg;

    localparam int TILE_W = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_Q_WANT = 3'd1,
        S_E_WANT = 3'd2,
        S_Q_CUR  = 3'd3,
        S_E_CUR  = 3'd4
    } state_t;

    // Joystick decode: up > left > down > right; no request keeps the old heading.
    function automatic dir_t joy_pick(input logic [3:0] joy, input dir_t hold);
        dir_t d;
        d = hold;
        if (joy[0])      d = DIR_UP;
        else if (joy[1]) d = DIR_LEFT;
        else if (joy[2]) d = DIR_DOWN;
        else if (joy[3]) d = DIR_RIGHT;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pacman_step_calc.sv
`default_nettype none
// ============================================================================
// Module   : pacman_step_calc
// Brief    : Neighbour tile of (x, y) in heading dir, plus its border-legal flag.
// Revision : 1.0 - initial release
// ============================================================================
module pacman_step_calc
    import pacman_mover_pkg::*;
#(
    parameter int BORDER_X_MIN = 1,
    parameter int BORDER_X_MAX = 28,
    parameter int BORDER_Y_MIN = 1,
    parameter int BORDER_Y_MAX = 28
) (
    input  logic [TILE_W-1:0] x,
    input  logic [TILE_W-1:0] y,
    input  dir_t              dir,
    output logic [TILE_W-1:0] nx,
    output logic [TILE_W-1:0] ny,
    output logic              legal
);

    localparam logic [TILE_W-1:0] c_one   = TILE_W'(1);
    localparam logic [TILE_W-1:0] c_x_min = TILE_W'(BORDER_X_MIN);
    localparam logic [TILE_W-1:0] c_x_max = TILE_W'(BORDER_X_MAX);
    localparam logic [TILE_W-1:0] c_y_min = TILE_W'(BORDER_Y_MIN);
    localparam logic [TILE_W-1:0] c_y_max = TILE_W'(BORDER_Y_MAX);

    // Modulo arithmetic: 0-1 wraps to 31, which the border test rejects.
    always_comb begin
        nx = x;
        ny = y;
        case (dir)
            DIR_UP:    ny = y - c_one;
            DIR_LEFT:  nx = x - c_one;
            DIR_DOWN:  ny = y + c_one;
            DIR_RIGHT: nx = x + c_one;
            default:   nx = x;
        endcase
        legal = (nx > c_x_min) && (nx < c_x_max) && (ny > c_y_min) && (ny < c_y_max);
    end

endmodule
`default_nettype wire

// File: rtl/pacman_mover.sv
`default_nettype none
// ============================================================================
// Module   : pacman_mover
// Brief    : Tile-based Pacman movement: periodic step attempts in the wanted
//            heading with fallback to the current heading, checked against the map.
// Revision : 1.0 - initial release
// ============================================================================
module pacman_mover
    import pacman_mover_pkg::*;
#(
    parameter int BORDER_X_MIN = 1,
    parameter int BORDER_X_MAX = 28,
    parameter int BORDER_Y_MIN = 1,
    parameter int BORDER_Y_MAX = 28,
    parameter int STEP_PERIOD  = 14,
    parameter int START_X      = 2,
    parameter int START_Y      = 2,
    parameter int START_DIR    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [3:0]        joy,
    input  logic              query_wall,
    output logic [TILE_W-1:0] query_x,
    output logic [TILE_W-1:0] query_y,
    output logic [TILE_W-1:0] xpos,
    output logic [TILE_W-1:0] ypos,
    output logic [1:0]        direction,
    output logic              moving,
    output logic              step
);

    localparam logic [3:0]        c_period    = 4'(STEP_PERIOD);
    localparam logic [TILE_W-1:0] c_start_x   = TILE_W'(START_X);
    localparam logic [TILE_W-1:0] c_start_y   = TILE_W'(START_Y);
    localparam dir_t              c_start_dir = dir_t'(2'(START_DIR));

    logic [3:0]        r_cnt;
    logic              w_tick;
    state_t            r_state;
    dir_t              r_want;
    dir_t              r_dir;
    dir_t              r_qdir;
    logic              r_qlegal;
    logic [TILE_W-1:0] r_qx, r_qy, r_x, r_y;
    logic              r_moving, r_step;
    dir_t              w_calc_dir;
    logic [TILE_W-1:0] w_nx, w_ny;
    logic              w_legal;

    assign w_tick = ce && (r_cnt >= c_period);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   r_cnt <= 4'd0;
        else if (ce) r_cnt <= w_tick ? 4'd0 : r_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_want <= c_start_dir;
        else       r_want <= joy_pick(joy, r_want);
    end

    // One calculator serves both phases: wanted heading from IDLE, current heading from E_WANT.
    assign w_calc_dir = (r_state == S_E_WANT) ? r_dir : r_want;

    pacman_step_calc #(
        .BORDER_X_MIN (BORDER_X_MIN),
        .BORDER_X_MAX (BORDER_X_MAX),
        .BORDER_Y_MIN (BORDER_Y_MIN),
        .BORDER_Y_MAX (BORDER_Y_MAX)
    ) u_calc (
        .x     (r_x),
        .y     (r_y),
        .dir   (w_calc_dir),
        .nx    (w_nx),
        .ny    (w_ny),
        .legal (w_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_x      <= c_start_x;
            r_y      <= c_start_y;
            r_dir    <= c_start_dir;
            r_qdir   <= c_start_dir;
            r_qlegal <= 1'b0;
            r_qx     <= '0;
            r_qy     <= '0;
            r_moving <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_qx     <= w_nx;
                        r_qy     <= w_ny;
                        r_qlegal <= w_legal;
                        r_qdir   <= r_want;
                        r_state  <= S_Q_WANT;
                    end
                end
                S_Q_WANT: r_state <= S_E_WANT;
                S_E_WANT: begin
                    if (!query_wall && r_qlegal) begin
                        r_x      <= r_qx;
                        r_y      <= r_qy;
                        r_dir    <= r_qdir;
                        r_moving <= 1'b1;
                        r_step   <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_qx     <= w_nx;
                        r_qy     <= w_ny;
                        r_qlegal <= w_legal;
                        r_state  <= S_Q_CUR;
                    end
                end
                S_Q_CUR: r_state <= S_E_CUR;
                S_E_CUR: begin
                    if (!query_wall && r_qlegal) begin
                        r_x      <= r_qx;
                        r_y      <= r_qy;
                        r_moving <= 1'b1;
                        r_step   <= 1'b1;
                    end else begin
                        r_moving <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign query_x   = r_qx;
    assign query_y   = r_qy;
    assign xpos      = r_x;
    assign ypos      = r_y;
    assign direction = r_dir;
    assign moving    = r_moving;
    assign step      = r_step;

endmodule
`default_nettype wire
